interrupt_ack_sequencer: RTL and testbench



---
 rtl/int_pkg.sv | 28 ++
 rtl/interrupt_ack_sequencer_if.sv | 15 +
 rtl/interrupt_ack_sequencer_nest_stack.sv | 51 +++++
 rtl/interrupt_ack_sequencer.sv | 147 ++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// The optional INT_ACK_NEST_EN macro is consumed by interrupt_ack_sequencer.sv.
package int_pkg;

  localparam int ID_W   = 5;
  localparam int PRIO_W = 3;

  // Thread-level running priority: lower than every real priority (0..7).
  localparam logic [3:0] IDLE_PRIO = 4'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ENTER = 2'd2,
    EXIT  = 2'd3
  } ack_state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [PRIO_W-1:0] prio;
  } int_entry_t;

  // Vector table holds 4-byte entries; wrap-around of the add is ignored.
  function automatic logic [31:0] vec_of(input logic [31:0] base, input logic [ID_W-1:0] id);
    return base + {25'b0, id, 2'b00};
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Core-side vectoring handshake between the sequencer (master) and the core (slave).
interface interrupt_ack_sequencer_if;

  // take_req/vec_addr are held stable from assertion until take_ack is seen
  // high at a rising edge; the transfer completes on that edge. reti is an
  // independent single-cycle pulse from the core.
  logic        take_req;
  logic [31:0] vec_addr;
  logic        take_ack;
  logic        reti;

  modport master (output take_req, output vec_addr, input take_ack, input reti);
  modport slave  (input take_req, input vec_addr, output take_ack, output reti);

endinterface

// File: rtl/interrupt_ack_sequencer_nest_stack.sv
// LIFO of active interrupts {id, prio}; push and pop are never simultaneous.
module int_nest_stack
  import int_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  int_entry_t din,
  output int_entry_t top,
  output logic [3:0] depth,
  output logic       full,
  output logic       empty
);

  // Storage is sized for the maximum legal depth; only DEPTH slots are reachable.
  int_entry_t mem_q [8];
  int_entry_t mem_d [8];
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] top_idx;

  assign full    = (cnt_q == 4'(DEPTH));
  assign empty   = (cnt_q == 4'd0);
  assign depth   = cnt_q;
  assign top_idx = cnt_q[2:0] - 3'd1;
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[cnt_q[2:0]] = din;
      cnt_d             = cnt_q + 4'd1;
    end else if (pop && !empty) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Processor-side interrupt responder: preemption decision, vector handshake, ack pulses.
// Define INT_ACK_NEST_EN for nesting up to DEPTH; otherwise one active interrupt at a time.
module interrupt_ack_sequencer
  import int_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        gie,
  input  logic                        int_flag,
  input  logic [ID_W-1:0]             int_ID,
  input  logic [PRIO_W-1:0]           _priority,
  input  logic [31:0]                 ivt_base,
  interrupt_ack_sequencer_if.master   core,
  output logic                        ack_start,
  output logic [ID_W-1:0]             ack_start_id,
  output logic                        ack_end,
  output logic [ID_W-1:0]             ack_end_id,
  output logic [3:0]                  cur_prio,
  output logic [3:0]                  nest_depth,
  output logic                        proto_err,
  output ack_state_t                  dbg_state
);

`ifdef INT_ACK_NEST_EN
  localparam int EFF_DEPTH = DEPTH;
`else
  localparam int EFF_DEPTH = (DEPTH > 1) ? 1 : DEPTH;
`endif

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_REQ   = REQ;
  localparam logic [1:0] S_ENTER = ENTER;
  localparam logic [1:0] S_EXIT  = EXIT;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [PRIO_W-1:0] prio_q, prio_d;
  logic [31:0]       vec_q, vec_d;
  logic [ID_W-1:0]   ack_start_id_q, ack_start_id_d;
  logic [ID_W-1:0]   ack_end_id_q, ack_end_id_d;
  logic              reti_pend_q, reti_pend_d;
  logic              proto_err_q, proto_err_d;

  logic       push, pop, full, empty, eligible, eff_reti;
  int_entry_t entry, top;
  logic [3:0] depth;

  assign entry = '{id: id_q, prio: prio_q};

  int_nest_stack #(.DEPTH(EFF_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .top   (top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // Strict less-than: equal priority never preempts, which also masks the
  // just-acknowledged ID the controller still shows right after ENTER.
  assign eligible = int_flag & gie & ({1'b0, _priority} < cur_prio) & ~full;
  assign eff_reti = core.reti | reti_pend_q;

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    prio_d         = prio_q;
    vec_d          = vec_q;
    ack_start_id_d = ack_start_id_q;
    ack_end_id_d   = ack_end_id_q;
    reti_pend_d    = reti_pend_q | core.reti;
    proto_err_d    = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eff_reti && !empty) begin
          state_d      = S_EXIT;
          ack_end_id_d = top.id;
        end else if (eff_reti) begin
          proto_err_d = 1'b1;
          reti_pend_d = 1'b0;
        end else if (eligible) begin
          id_d    = int_ID;
          prio_d  = _priority;
          vec_d   = vec_of(ivt_base, int_ID);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (core.take_ack) begin
          state_d        = S_ENTER;
          ack_start_id_d = id_q;
        end
      end
      S_ENTER: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      S_EXIT: begin
        pop         = 1'b1;
        reti_pend_d = core.reti;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      id_q           <= '0;
      prio_q         <= '0;
      vec_q          <= '0;
      ack_start_id_q <= '0;
      ack_end_id_q   <= '0;
      reti_pend_q    <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      prio_q         <= prio_d;
      vec_q          <= vec_d;
      ack_start_id_q <= ack_start_id_d;
      ack_end_id_q   <= ack_end_id_d;
      reti_pend_q    <= reti_pend_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign core.take_req = (state_q == S_REQ);
  assign core.vec_addr = vec_q;
  assign ack_start     = (state_q == S_ENTER);
  assign ack_start_id  = ack_start_id_q;
  assign ack_end       = (state_q == S_EXIT);
  assign ack_end_id    = ack_end_id_q;
  assign cur_prio      = empty ? IDLE_PRIO : {1'b0, top.prio};
  assign nest_depth    = depth;
  assign proto_err     = proto_err_q;
  assign dbg_state     = ack_state_t'(state_q);

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer (DEPTH=2), covering both INT_ACK_NEST_EN builds.
module tb_interrupt_ack_sequencer;
  import int_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gie = 1'b1;
  logic        int_flag = 1'b0;
  logic [4:0]  int_ID = '0;
  logic [2:0]  _priority = '0;
  logic [31:0] ivt_base = '0;
  logic        ack_start, ack_end, proto_err;
  logic [4:0]  ack_start_id, ack_end_id;
  logic [3:0]  cur_prio, nest_depth;
  ack_state_t  dbg_state;
  int          total = 0;
  int          bad = 0;

  interrupt_ack_sequencer_if core_if ();

  interrupt_ack_sequencer #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .gie          (gie),
    .int_flag     (int_flag),
    .int_ID       (int_ID),
    ._priority    (_priority),
    .ivt_base     (ivt_base),
    .core         (core_if),
    .ack_start    (ack_start),
    .ack_start_id (ack_start_id),
    .ack_end      (ack_end),
    .ack_end_id   (ack_end_id),
    .cur_prio     (cur_prio),
    .nest_depth   (nest_depth),
    .proto_err    (proto_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [4:0] id, input logic [2:0] pr);
    int_flag  = 1'b1;
    int_ID    = id;
    _priority = pr;
  endtask

  // Full entry: request, handshake, push. int_flag is left high for the caller.
  task automatic do_entry(input logic [4:0] id, input logic [2:0] pr, input logic [31:0] base,
                          input logic [31:0] exp_vec, input logic [3:0] exp_depth);
    set_req(id, pr);
    ivt_base = base;
    step();
    check("take_req_up", core_if.take_req, 1);
    check("vec_addr", core_if.vec_addr, exp_vec);
    core_if.take_ack = 1'b1;
    step();
    check("ack_start_up", ack_start, 1);
    check("ack_start_id", ack_start_id, 32'(id));
    core_if.take_ack = 1'b0;
    step();
    check("ack_start_down", ack_start, 0);
    check("cur_prio_enter", cur_prio, 32'(pr));
    check("depth_enter", nest_depth, 32'(exp_depth));
  endtask

  task automatic do_exit(input logic [4:0] exp_id, input logic [3:0] exp_prio, input logic [3:0] exp_depth);
    core_if.reti = 1'b1;
    step();
    check("ack_end_up", ack_end, 1);
    check("ack_end_id", ack_end_id, 32'(exp_id));
    core_if.reti = 1'b0;
    step();
    check("ack_end_down", ack_end, 0);
    check("cur_prio_exit", cur_prio, 32'(exp_prio));
    check("depth_exit", nest_depth, 32'(exp_depth));
  endtask

  initial begin
    core_if.take_ack = 1'b0;
    core_if.reti     = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_take_req", core_if.take_req, 0);
    check("rst_vec_addr", core_if.vec_addr, 0);
    check("rst_ack_start", ack_start, 0);
    check("rst_ack_start_id", ack_start_id, 0);
    check("rst_ack_end", ack_end, 0);
    check("rst_ack_end_id", ack_end_id, 0);
    check("rst_cur_prio", cur_prio, 8);
    check("rst_depth", nest_depth, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // gie low masks an otherwise eligible request
    gie = 1'b0;
    set_req(5'd4, 3'd0);
    step();
    step();
    check("gie_mask", core_if.take_req, 0);
    int_flag = 1'b0;
    gie = 1'b1;
    step();

    // Single interrupt; same ID still pending after ENTER must not re-enter
    do_entry(5'd5, 3'd1, 32'h1000, 32'h1014, 4'd1);
    step();
    check("equal_after_enter", core_if.take_req, 0);
    int_flag = 1'b0;
    do_exit(5'd5, 4'h8, 4'd0);

    // Equal and lower priority blocked; reti together with pending request
    do_entry(5'd5, 3'd1, 32'h0, 32'h14, 4'd1);
    set_req(5'd6, 3'd1);
    step();
    check("equal_blocked", core_if.take_req, 0);
    set_req(5'd20, 3'd5);
    step();
    check("lower_blocked", core_if.take_req, 0);
    set_req(5'd6, 3'd1);
    core_if.reti = 1'b1;
    step();
    check("exit_wins_end", ack_end, 1);
    check("exit_wins_id", ack_end_id, 5);
    check("exit_wins_noreq", core_if.take_req, 0);
    core_if.reti = 1'b0;
    step();
    check("post_exit_noreq", core_if.take_req, 0);
    check("post_exit_depth", nest_depth, 0);
    step();
    check("reeval_req", core_if.take_req, 1);
    check("reeval_vec", core_if.vec_addr, 32'h18);
    core_if.take_ack = 1'b1;
    step();
    check("reeval_ack_id", ack_start_id, 6);
    core_if.take_ack = 1'b0;
    int_flag = 1'b0;
    step();
    check("reeval_prio", cur_prio, 1);
    do_exit(5'd6, 4'h8, 4'd0);

    // reti on an empty stack
    core_if.reti = 1'b1;
    step();
    check("proto_err_up", proto_err, 1);
    check("proto_no_end", ack_end, 0);
    core_if.reti = 1'b0;
    step();
    check("proto_err_down", proto_err, 0);
    check("proto_no_end2", ack_end, 0);
    check("proto_state", 32'(dbg_state), 32'(IDLE));

`ifdef INT_ACK_NEST_EN
    // Preemption to full depth, full blocks prio 0, reti beats eligible request
    do_entry(5'd9, 3'd3, 32'h2000, 32'h2024, 4'd1);
    do_entry(5'd2, 3'd1, 32'h2000, 32'h2008, 4'd2);
    set_req(5'd1, 3'd0);
    step();
    step();
    check("full_blocked", core_if.take_req, 0);
    check("full_depth", nest_depth, 2);
    int_flag = 1'b0;
    do_exit(5'd2, 4'd3, 4'd1);
    set_req(5'd1, 3'd0);
    core_if.reti = 1'b1;
    step();
    check("nest_exit_wins", ack_end_id, 9);
    check("nest_exit_noreq", core_if.take_req, 0);
    core_if.reti = 1'b0;
    step();
    check("nest_after_exit", core_if.take_req, 0);
    step();
    check("nest_reeval_req", core_if.take_req, 1);
    check("nest_reeval_vec", core_if.vec_addr, 32'h2004);
    core_if.take_ack = 1'b1;
    step();
    check("nest_reeval_id", ack_start_id, 1);
    core_if.take_ack = 1'b0;
    int_flag = 1'b0;
    step();
    check("nest_reeval_prio", cur_prio, 0);
    do_exit(5'd1, 4'h8, 4'd0);
`else
    // Single level: higher priority waits for ack_end
    do_entry(5'd9, 3'd2, 32'h2000, 32'h2024, 4'd1);
    set_req(5'd2, 3'd0);
    step();
    step();
    check("no_nest_blocked", core_if.take_req, 0);
    check("no_nest_depth", nest_depth, 1);
    core_if.reti = 1'b1;
    step();
    check("single_exit_end", ack_end, 1);
    check("single_exit_id", ack_end_id, 9);
    check("single_exit_noreq", core_if.take_req, 0);
    core_if.reti = 1'b0;
    step();
    check("single_after_exit", core_if.take_req, 0);
    check("single_after_prio", cur_prio, 8);
    step();
    check("single_reeval_req", core_if.take_req, 1);
    check("single_reeval_vec", core_if.vec_addr, 32'h2008);
    core_if.take_ack = 1'b1;
    step();
    check("single_reeval_id", ack_start_id, 2);
    core_if.take_ack = 1'b0;
    int_flag = 1'b0;
    step();
    check("single_reeval_prio", cur_prio, 0);
    do_exit(5'd2, 4'h8, 4'd0);
`endif

    // Reset asserted while waiting in REQ
    set_req(5'd3, 3'd4);
    ivt_base = 32'h0;
    step();
    check("pre_rst_req", core_if.take_req, 1);
    int_flag = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_drop_req", core_if.take_req, 0);
    check("rst_mid_prio", cur_prio, 8);
    check("rst_mid_vec", core_if.vec_addr, 0);
    step();
    rst = 1'b0;
    step();
    check("rst_no_ack_start", ack_start, 0);
    check("rst_no_ack_end", ack_end, 0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
